// File: rtl/branch_hazard_unit.sv
// Branch hazard control for the ID-stage branch comparator: operand forwarding selects,
// front-end stalls for unresolved operands, PC redirect/flush, and saturating statistics.
module branch_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IFID_Valid,
    input  logic             IsBranch,
    input  logic [4:0]       IFID_Rs1,
    input  logic [4:0]       IFID_Rs2,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rd,
    input  logic             EXMEM_RegWrite,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_Rd,
    input  logic             MEMWB_RegWrite,
    input  logic [4:0]       MEMWB_Rd,
    input  logic             BranchCmp,
    output logic [1:0]       Ctrl_Mux_1_Branch,
    output logic [1:0]       Ctrl_Mux_2_Branch,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Bubble_IDEX,
    output logic             PC_Src,
    output logic             Flush_IFID,
    output logic [CNT_W-1:0] Branch_Count,
    output logic [CNT_W-1:0] Taken_Count,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef enum logic [0:0] {IDLE, LOAD_WAIT} state_t;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state, state_nxt;

    logic br;
    logic rs1_idex, rs1_exmem, rs1_memwb;
    logic rs2_idex, rs2_exmem, rs2_memwb;
    logic [1:0] need1, need2, need;
    logic [1:0] sel1, sel2;
    logic resolve;

    assign br = IFID_Valid & IsBranch;

    // x0 is hardwired to zero, so a write to it can never create a dependence.
    assign rs1_idex  = IDEX_RegWrite  && (IDEX_Rd  == IFID_Rs1) && (IDEX_Rd  != 5'd0);
    assign rs1_exmem = EXMEM_RegWrite && (EXMEM_Rd == IFID_Rs1) && (EXMEM_Rd != 5'd0);
    assign rs1_memwb = MEMWB_RegWrite && (MEMWB_Rd == IFID_Rs1) && (MEMWB_Rd != 5'd0);
    assign rs2_idex  = IDEX_RegWrite  && (IDEX_Rd  == IFID_Rs2) && (IDEX_Rd  != 5'd0);
    assign rs2_exmem = EXMEM_RegWrite && (EXMEM_Rd == IFID_Rs2) && (EXMEM_Rd != 5'd0);
    assign rs2_memwb = MEMWB_RegWrite && (MEMWB_Rd == IFID_Rs2) && (MEMWB_Rd != 5'd0);

    function automatic logic [1:0] need_of(input logic idex_hit, input logic exmem_hit);
        if (idex_hit)
            return IDEX_MemRead ? 2'd2 : 2'd1;
        else if (exmem_hit && EXMEM_MemRead)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [1:0] sel_of(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit && !EXMEM_MemRead)
            return SEL_EXMEM;
        else if (memwb_hit)
            return SEL_MEMWB;
        else
            return SEL_RF;
    endfunction

    assign need1 = need_of(rs1_idex, rs1_exmem);
    assign need2 = need_of(rs2_idex, rs2_exmem);
    assign need  = (need1 > need2) ? need1 : need2;
    assign sel1  = sel_of(rs1_exmem, rs1_memwb);
    assign sel2  = sel_of(rs2_exmem, rs2_memwb);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt         = state;
        Ctrl_Mux_1_Branch = SEL_RF;
        Ctrl_Mux_2_Branch = SEL_RF;
        Stall_PC          = 1'b0;
        Stall_IFID        = 1'b0;
        Bubble_IDEX       = 1'b0;
        PC_Src            = 1'b0;
        Flush_IFID        = 1'b0;
        resolve           = 1'b0;
        // Outputs stay quiet while reset is held, even with a hazard on the inputs.
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (br) begin
                        if (need != 2'd0) begin
                            Stall_PC    = 1'b1;
                            Stall_IFID  = 1'b1;
                            Bubble_IDEX = 1'b1;
                            if (need == 2'd2)
                                state_nxt = LOAD_WAIT;
                        end else begin
                            resolve           = 1'b1;
                            Ctrl_Mux_1_Branch = sel1;
                            Ctrl_Mux_2_Branch = sel2;
                            PC_Src            = BranchCmp;
                            Flush_IFID        = BranchCmp;
                        end
                    end
                end
                LOAD_WAIT: begin
                    Stall_PC    = 1'b1;
                    Stall_IFID  = 1'b1;
                    Bubble_IDEX = 1'b1;
                    state_nxt   = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Branch_Count <= '0;
            Taken_Count  <= '0;
            Stall_Count  <= '0;
        end else begin
            if (resolve && Branch_Count != CNT_MAX)
                Branch_Count <= Branch_Count + CNT_W'(1);
            if (resolve && BranchCmp && Taken_Count != CNT_MAX)
                Taken_Count <= Taken_Count + CNT_W'(1);
            if (Stall_PC && Stall_Count != CNT_MAX)
                Stall_Count <= Stall_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench for branch_hazard_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model (CNT_W=16 and CNT_W=2).
module tb_branch_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic IFID_Valid = 1'b0, IsBranch = 1'b0, BranchCmp = 1'b0;
    logic [4:0] IFID_Rs1 = '0, IFID_Rs2 = '0;
    logic IDEX_RegWrite = 1'b0, IDEX_MemRead = 1'b0;
    logic [4:0] IDEX_Rd = '0;
    logic EXMEM_RegWrite = 1'b0, EXMEM_MemRead = 1'b0;
    logic [4:0] EXMEM_Rd = '0;
    logic MEMWB_RegWrite = 1'b0;
    logic [4:0] MEMWB_Rd = '0;

    logic [1:0] Ctrl_Mux_1_Branch, Ctrl_Mux_2_Branch;
    logic Stall_PC, Stall_IFID, Bubble_IDEX, PC_Src, Flush_IFID;
    logic [15:0] Branch_Count, Taken_Count, Stall_Count;

    logic [1:0] s_mux1, s_mux2;
    logic s_stall_pc, s_stall_ifid, s_bubble, s_pc_src, s_flush;
    logic [1:0] s_branch_cnt, s_taken_cnt, s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .IFID_Valid(IFID_Valid), .IsBranch(IsBranch),
        .IFID_Rs1(IFID_Rs1), .IFID_Rs2(IFID_Rs2),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd), .BranchCmp(BranchCmp),
        .Ctrl_Mux_1_Branch(Ctrl_Mux_1_Branch), .Ctrl_Mux_2_Branch(Ctrl_Mux_2_Branch),
        .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID), .Bubble_IDEX(Bubble_IDEX),
        .PC_Src(PC_Src), .Flush_IFID(Flush_IFID),
        .Branch_Count(Branch_Count), .Taken_Count(Taken_Count), .Stall_Count(Stall_Count)
    );

    branch_hazard_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .IFID_Valid(IFID_Valid), .IsBranch(IsBranch),
        .IFID_Rs1(IFID_Rs1), .IFID_Rs2(IFID_Rs2),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_Rd(EXMEM_Rd),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd), .BranchCmp(BranchCmp),
        .Ctrl_Mux_1_Branch(s_mux1), .Ctrl_Mux_2_Branch(s_mux2),
        .Stall_PC(s_stall_pc), .Stall_IFID(s_stall_ifid), .Bubble_IDEX(s_bubble),
        .PC_Src(s_pc_src), .Flush_IFID(s_flush),
        .Branch_Count(s_branch_cnt), .Taken_Count(s_taken_cnt), .Stall_Count(s_stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // forced_stalls: cycles of unconditional stall still owed to a load in flight.
    int forced_stalls = 0;
    int m_branches = 0, m_taken = 0, m_stalls = 0;

    function automatic bit writes(input logic rw, input logic [4:0] rd, input logic [4:0] rs);
        return rw && rd == rs && rs != 5'd0;
    endfunction

    function automatic int src_need(input logic [4:0] rs);
        int n = 0;
        if (writes(EXMEM_RegWrite, EXMEM_Rd, rs) && EXMEM_MemRead) n = 1;
        if (writes(IDEX_RegWrite, IDEX_Rd, rs)) n = IDEX_MemRead ? 2 : 1;
        return n;
    endfunction

    function automatic int src_fwd(input logic [4:0] rs);
        if (writes(EXMEM_RegWrite, EXMEM_Rd, rs) && !EXMEM_MemRead) return 1;
        if (writes(MEMWB_RegWrite, MEMWB_Rd, rs)) return 2;
        return 0;
    endfunction

    function automatic int total_need();
        int a = src_need(IFID_Rs1);
        int b = src_need(IFID_Rs2);
        return (a > b) ? a : b;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forced_stalls = 0;
            m_branches = 0; m_taken = 0; m_stalls = 0;
        end else if (forced_stalls > 0) begin
            m_stalls++;
            forced_stalls--;
        end else if (IFID_Valid && IsBranch) begin
            if (total_need() > 0) begin
                m_stalls++;
                forced_stalls = total_need() - 1;
            end else begin
                m_branches++;
                if (BranchCmp) m_taken++;
            end
        end
    end

    // Compare process: every negedge, both DUTs against the model.
    int e_mux1, e_mux2, e_stall, e_redirect;
    always @(negedge clk) begin
        e_mux1 = 0; e_mux2 = 0; e_stall = 0; e_redirect = 0;
        if (rst_n) begin
            if (forced_stalls > 0) e_stall = 1;
            else if (IFID_Valid && IsBranch) begin
                if (total_need() > 0) e_stall = 1;
                else begin
                    e_mux1 = src_fwd(IFID_Rs1);
                    e_mux2 = src_fwd(IFID_Rs2);
                    e_redirect = BranchCmp ? 1 : 0;
                end
            end
        end
        check("mux1", 32'(Ctrl_Mux_1_Branch), 32'(e_mux1));
        check("mux2", 32'(Ctrl_Mux_2_Branch), 32'(e_mux2));
        check("stall_pc", 32'(Stall_PC), 32'(e_stall));
        check("stall_ifid", 32'(Stall_IFID), 32'(e_stall));
        check("bubble_idex", 32'(Bubble_IDEX), 32'(e_stall));
        check("pc_src", 32'(PC_Src), 32'(e_redirect));
        check("flush_ifid", 32'(Flush_IFID), 32'(e_redirect));
        check("branch_count", 32'(Branch_Count), 32'(sat(m_branches, 65535)));
        check("taken_count", 32'(Taken_Count), 32'(sat(m_taken, 65535)));
        check("stall_count", 32'(Stall_Count), 32'(sat(m_stalls, 65535)));
        check("s_mux1", 32'(s_mux1), 32'(e_mux1));
        check("s_mux2", 32'(s_mux2), 32'(e_mux2));
        check("s_stall_pc", 32'(s_stall_pc), 32'(e_stall));
        check("s_stall_ifid", 32'(s_stall_ifid), 32'(e_stall));
        check("s_bubble", 32'(s_bubble), 32'(e_stall));
        check("s_pc_src", 32'(s_pc_src), 32'(e_redirect));
        check("s_flush", 32'(s_flush), 32'(e_redirect));
        check("s_branch_count", 32'(s_branch_cnt), 32'(sat(m_branches, 3)));
        check("s_taken_count", 32'(s_taken_cnt), 32'(sat(m_taken, 3)));
        check("s_stall_count", 32'(s_stall_cnt), 32'(sat(m_stalls, 3)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        IDEX_RegWrite = 0; IDEX_MemRead = 0; IDEX_Rd = 0;
        EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_Rd = 0;
        MEMWB_RegWrite = 0; MEMWB_Rd = 0;
    endtask

    task automatic branch(input logic [4:0] rs1, input logic [4:0] rs2, input logic cmp);
        IFID_Valid = 1; IsBranch = 1; IFID_Rs1 = rs1; IFID_Rs2 = rs2; BranchCmp = cmp;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stall_pc", 32'(Stall_PC), 32'd0);
        check("rst_branch_count", 32'(Branch_Count), 32'd0);
        @(posedge clk); #3 rst_n = 1;

        // Branch behind a load: stall, stall, resolve from MEMWB
        step();
        branch(5'd5, 5'd0, 1'b1);
        IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_Rd = 5'd5;
        @(negedge clk);
        check("ld_c0_stall", 32'(Stall_PC), 32'd1);
        check("ld_c0_pc_src", 32'(PC_Src), 32'd0);
        step();
        clear_pipe(); EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_Rd = 5'd5;
        @(negedge clk);
        check("ld_c1_stall", 32'(Stall_PC), 32'd1);
        check("ld_c1_mux1", 32'(Ctrl_Mux_1_Branch), 32'd0);
        step();
        clear_pipe(); MEMWB_RegWrite = 1; MEMWB_Rd = 5'd5;
        @(negedge clk);
        check("ld_c2_stall", 32'(Stall_PC), 32'd0);
        check("ld_c2_mux1", 32'(Ctrl_Mux_1_Branch), 32'd2);
        check("ld_c2_pc_src", 32'(PC_Src), 32'd1);
        check("ld_c2_flush", 32'(Flush_IFID), 32'd1);
        check("ld_c2_stall_cnt", 32'(Stall_Count), 32'd2);
        step();
        IFID_Valid = 0; clear_pipe();
        @(negedge clk);
        check("ld_c3_flush", 32'(Flush_IFID), 32'd0);
        check("ld_branch_cnt", 32'(Branch_Count), 32'd1);
        check("ld_taken_cnt", 32'(Taken_Count), 32'd1);
        check("ld_stall_cnt", 32'(Stall_Count), 32'd2);

        // Reset in the middle of LOAD_WAIT
        step();
        branch(5'd6, 5'd0, 1'b0);
        IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_Rd = 5'd6;
        step();
        #2 rst_n = 0;
        #1;
        check("rstlw_stall_pc", 32'(Stall_PC), 32'd0);
        check("rstlw_bubble", 32'(Bubble_IDEX), 32'd0);
        check("rstlw_branch_cnt", 32'(Branch_Count), 32'd0);
        check("rstlw_stall_cnt", 32'(Stall_Count), 32'd0);
        @(posedge clk); #3 rst_n = 1;
        clear_pipe();
        branch(5'd6, 5'd0, 1'b1);
        @(negedge clk);
        check("rstlw_idle_stall", 32'(Stall_PC), 32'd0);
        check("rstlw_idle_pc_src", 32'(PC_Src), 32'd1);

        // Five taken branches: 16-bit counters reach 5, 2-bit counters saturate at 3
        repeat (5) step();
        IFID_Valid = 0;
        @(negedge clk);
        check("sat_branch16", 32'(Branch_Count), 32'd5);
        check("sat_taken16", 32'(Taken_Count), 32'd5);
        check("sat_branch2", 32'(s_branch_cnt), 32'd3);
        check("sat_taken2", 32'(s_taken_cnt), 32'd3);

        // Branch behind an ALU op: one stall, then forward from EXMEM, not taken
        step();
        branch(5'd1, 5'd7, 1'b0);
        IDEX_RegWrite = 1; IDEX_Rd = 5'd7;
        @(negedge clk);
        check("alu_c0_stall", 32'(Stall_PC), 32'd1);
        step();
        clear_pipe(); EXMEM_RegWrite = 1; EXMEM_Rd = 5'd7;
        @(negedge clk);
        check("alu_c1_stall", 32'(Stall_PC), 32'd0);
        check("alu_c1_mux2", 32'(Ctrl_Mux_2_Branch), 32'd1);
        check("alu_c1_mux1", 32'(Ctrl_Mux_1_Branch), 32'd0);
        check("alu_c1_flush", 32'(Flush_IFID), 32'd0);
        step();
        IFID_Valid = 0; clear_pipe();
        @(negedge clk);
        check("alu_taken_cnt", 32'(Taken_Count), 32'd5);
        check("alu_branch_cnt", 32'(Branch_Count), 32'd6);

        // EXMEM beats MEMWB for the same source
        step();
        branch(5'd3, 5'd0, 1'b0);
        EXMEM_RegWrite = 1; EXMEM_Rd = 5'd3; MEMWB_RegWrite = 1; MEMWB_Rd = 5'd3;
        @(negedge clk);
        check("prio_mux1", 32'(Ctrl_Mux_1_Branch), 32'd1);
        // Both sources forwarding from different stages
        step();
        branch(5'd3, 5'd4, 1'b0);
        MEMWB_Rd = 5'd4;
        @(negedge clk);
        check("dual_mux1", 32'(Ctrl_Mux_1_Branch), 32'd1);
        check("dual_mux2", 32'(Ctrl_Mux_2_Branch), 32'd2);
        check("dual_stall", 32'(Stall_PC), 32'd0);

        // x0 never stalls or forwards
        step();
        clear_pipe();
        branch(5'd0, 5'd0, 1'b0);
        IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_Rd = 5'd0;
        EXMEM_RegWrite = 1; MEMWB_RegWrite = 1;
        @(negedge clk);
        check("x0_stall", 32'(Stall_PC), 32'd0);
        check("x0_mux1", 32'(Ctrl_Mux_1_Branch), 32'd0);
        check("x0_mux2", 32'(Ctrl_Mux_2_Branch), 32'd0);

        // Randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            step();
            IFID_Valid     = ($urandom_range(0, 7) != 0);
            IsBranch       = ($urandom_range(0, 3) != 0);
            IFID_Rs1       = 5'($urandom_range(0, 4));
            IFID_Rs2       = 5'($urandom_range(0, 4));
            IDEX_RegWrite  = ($urandom_range(0, 2) == 0);
            IDEX_MemRead   = 1'($urandom_range(0, 1));
            IDEX_Rd        = 5'($urandom_range(0, 4));
            EXMEM_RegWrite = 1'($urandom_range(0, 1));
            EXMEM_MemRead  = ($urandom_range(0, 3) == 0);
            EXMEM_Rd       = 5'($urandom_range(0, 4));
            MEMWB_RegWrite = 1'($urandom_range(0, 1));
            MEMWB_Rd       = 5'($urandom_range(0, 4));
            BranchCmp      = 1'($urandom_range(0, 1));
            if (i == 1500) begin
                #2 rst_n = 0;
                #2 rst_n = 1;
            end
        end
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

Control partner of the ID-stage branch comparator in the rv32 pipeline. It generates the comparator's operand-forwarding selects. It stalls the front end when a branch operand is not yet available, and consumes `BranchCmp` to redirect the PC and flush IF/ID. It also keeps saturating branch, taken and stall statistics counters.

## Interface
- `CNT_W`, 16: width of each statistics counter.

- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `IFID_Valid` in 1: IF/ID holds a real instruction.
- `IsBranch` in 1: IF/ID instruction is a conditional branch.
- `IFID_Rs1`, `IFID_Rs2` in 5 each: branch source registers.
- `IDEX_RegWrite`, `IDEX_MemRead` in 1 each; `IDEX_Rd` in 5.
- `EXMEM_RegWrite`, `EXMEM_MemRead` in 1 each; `EXMEM_Rd` in 5.
- `MEMWB_RegWrite` in 1; `MEMWB_Rd` in 5.
- `BranchCmp` in 1: comparator result, valid when operands are resolved.
- `Ctrl_Mux_1_Branch`, `Ctrl_Mux_2_Branch` out 2 each: 00 = register file, 01 = EXMEM ALU data, 10 = MEMWB data.
- `Stall_PC`, `Stall_IFID` out 1 each: hold PC and IF/ID.
- `Bubble_IDEX` out 1: insert a NOP into ID/EX.
- `PC_Src` out 1: select the branch target.
- `Flush_IFID` out 1: squash the instruction in IF/ID.
- `Branch_Count`, `Taken_Count`, `Stall_Count` out CNT_W each.

## Operation
- A source is matched by stage X when `X_RegWrite` is set, `X_Rd` equals the source register, and `X_Rd` is not 0.
- `br` = `IFID_Valid` & `IsBranch`.
- Hazard need, evaluated per source and taking the maximum:
  - IDEX match with `IDEX_MemRead` set: 2 stall cycles.
  - IDEX match otherwise: 1.
  - EXMEM match with `EXMEM_MemRead` set: 1.
  - No match in these cases: 0.
- Forward select per source when need = 0:
  - EXMEM match (not a load): 01.
  - Otherwise MEMWB match: 10.
  - Otherwise 00.
  - EXMEM has priority over MEMWB.
- FSM states: IDLE, LOAD_WAIT.
  - IDLE, `br` with need ≥ 1: assert `Stall_PC`, `Stall_IFID`, `Bubble_IDEX`. Need = 2 moves to LOAD_WAIT; need = 1 stays in IDLE and re-evaluates next cycle.
  - IDLE, `br` with need = 0 (resolve cycle): drive forward selects. If `BranchCmp` = 1, assert `PC_Src` and `Flush_IFID`.
  - LOAD_WAIT: assert the three stall outputs; selects are 00; `PC_Src` and `Flush_IFID` are 0. Return to IDLE unconditionally after one cycle.
- `Flush_IFID` lasts exactly one cycle because the next IF/ID content is the squashed fetch.
- When `br` = 0, no stall and no redirect occur, and selects are 00.
- Counters saturate at 2^CNT_W-1 and never wrap:
  - `Branch_Count` +1 each resolve cycle.
  - `Taken_Count` +1 each resolve cycle with `BranchCmp` = 1.
  - `Stall_Count` +1 each cycle `Stall_PC` = 1.

## Timing
- Reset (async, `rst_n` low): state = IDLE, all counters 0, all outputs 0. Reset mid-LOAD_WAIT returns to IDLE immediately.
- Selects, stall, `PC_Src` and `Flush_IFID` are combinational from the current state and inputs in the same cycle. State and counters update on the rising edge.
- Branch behind a load in ID/EX:
  - Cycle 0: detect and stall.
  - Cycle 1: LOAD_WAIT, stall.
  - Cycle 2: resolve with select 10.
- Branch behind an ALU op in ID/EX: stall one cycle, then resolve with select 01.
- When both sources have different needs, the larger need wins. Both sources may forward from different stages in the same cycle.
- A source equal to x0 never stalls or forwards.

## Test plan
- Reset with `rst_n`=0 mid-LOAD_WAIT -> outputs 0, counters 0, state IDLE on the next edge check.
- Branch rs1=5, IDEX load rd=5 -> `Stall_PC`=1 for 2 cycles. Cycle 2 then gives `Ctrl_Mux_1_Branch`=10; with `BranchCmp`=1, `PC_Src`=`Flush_IFID`=1 for one cycle. `Stall_Count`=2, `Branch_Count`=1, `Taken_Count`=1.
- Branch rs2=7, IDEX ALU rd=7 -> 1 stall cycle, then `Ctrl_Mux_2_Branch`=01. With `BranchCmp`=0, no flush; `Taken_Count` unchanged.
- rs1=3 matched by EXMEM rd=3 and MEMWB rd=3, rs2=4 matched by MEMWB only -> selects 01/10, no stall.
- rs1=0 with IDEX load rd=0 -> no stall, select 00.
- CNT_W=2: run 5 taken branches -> `Branch_Count`=`Taken_Count`=3 (saturated).
